serial_subtractor_calc: RTL and testbench



---
 rtl/calc_pkg.sv | 34 +++
 rtl/debounce.sv | 45 ++++
 rtl/segment_decoder.sv | 22 ++
 rtl/serial_subtractor_4bit.sv | 60 ++++++
 rtl/serial_subtractor_calc.sv | 112 +++++++++++
 tb/tb_serial_subtractor_calc.sv | 195 +++++++++++++++++++
 6 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the button-driven 4-bit calculators.
// This includes the FSM encoding, the operand width and the seven-segment glyphs.
package calc_pkg;

  localparam int W        = 4;
  localparam int DB_DEPTH = 4;  // clocks a raw button level must hold before it is accepted

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_CALC = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  // Active-high glyphs, bit order {dp,g,f,e,d,c,b,a}
  function automatic logic [7:0] seg_pattern(input logic [3:0] digit);
    logic [7:0] pat;
    case (digit)
      4'd0:    pat = 8'h3F;
      4'd1:    pat = 8'h06;
      4'd2:    pat = 8'h5B;
      4'd3:    pat = 8'h4F;
      4'd4:    pat = 8'h66;
      4'd5:    pat = 8'h6D;
      4'd6:    pat = 8'h7D;
      4'd7:    pat = 8'h07;
      4'd8:    pat = 8'h7F;
      4'd9:    pat = 8'h6F;
      default: pat = 8'h00;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/debounce.sv
// Button debouncer with a two-flop synchronizer and a stability counter.
// It emits a single-cycle pulse when a press becomes stable. The reset is synchronous and active-low.
module debounce #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_pulse
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [1:0]    r_sync;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          r_pulse;

  // Accept a new level only after it has differed from the stable level for DEPTH clocks
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync   <= 2'b00;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_pulse  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_raw};
      r_pulse <= 1'b0;
      if (r_sync[1] != r_stable) begin
        if (r_cnt == CNT_MAX) begin
          r_stable <= r_sync[1];
          r_cnt    <= '0;
          r_pulse  <= r_sync[1];
        end else begin
          r_cnt <= r_cnt + CNT_ONE;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_pulse = r_pulse;
endmodule

// File: rtl/segment_decoder.sv
// Splits a 0..15 value into a tens digit and a units digit.
// Each digit is driven out as a seven-segment glyph.
module segment_decoder
  import calc_pkg::*;
(
  input  logic [3:0] i_num,
  output logic [7:0] o_seg_tens,
  output logic [7:0] o_seg_units
);
  // Two-digit split of a 4-bit value
  always_comb begin
    o_seg_tens  = seg_pattern(4'd0);
    o_seg_units = seg_pattern(i_num);
    if (i_num >= 4'd10) begin
      o_seg_tens  = seg_pattern(4'd1);
      o_seg_units = seg_pattern(i_num - 4'd10);
    end else begin
      o_seg_tens  = seg_pattern(4'd0);
      o_seg_units = seg_pattern(i_num);
    end
  end
endmodule

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial ripple-borrow subtractor that processes one bit per clock, LSB first.
// done pulses for one cycle once all four bits have been shifted.
module serial_subtractor_4bit
  import calc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         done
);
  logic [W-1:0] r_a, r_b, r_d;
  logic [1:0]   r_cnt;
  logic         r_br, r_run, r_done;
  logic         w_d, w_br_next;

  assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);

  // Operand load on start, then four shift steps
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_d    <= '0;
      r_cnt  <= 2'd0;
      r_br   <= 1'b0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_a   <= a;
        r_b   <= b;
        r_d   <= '0;
        r_br  <= bin;
        r_cnt <= 2'd0;
        r_run <= 1'b1;
      end else if (r_run) begin
        r_d   <= {w_d, r_d[W-1:1]};
        r_a   <= {1'b0, r_a[W-1:1]};
        r_b   <= {1'b0, r_b[W-1:1]};
        r_br  <= w_br_next;
        r_cnt <= r_cnt + 2'd1;
        if (r_cnt == 2'd3) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign diff = r_d;
  assign bout = r_br;
  assign done = r_done;
endmodule

// File: rtl/serial_subtractor_calc.sv
// Button-driven 4-bit subtraction calculator.
// It takes A, then B, runs the serial engine and shows A - B - bin on two digits.
module serial_subtractor_calc
  import calc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] Input,
  input  logic         btn,
  input  logic         bin,
  output logic [7:0]   seg1,
  output logic [7:0]   seg2,
  output logic         bin_status,
  output logic         bout,
  output logic         busy
);
  state_t       r_state, w_next_state;
  logic [W-1:0] r_num_a, r_show_number, w_diff;
  logic         r_bin_status, r_bout, r_busy;
  logic         w_rst_n, w_change, w_bin_pulse, w_start, w_done, w_eng_bout, w_bin_allowed;

  assign w_rst_n = ~rst;

  debounce #(.DEPTH(DB_DEPTH)) u_db_btn (
    .clk(clk), .rst_n(w_rst_n), .i_raw(btn), .o_pulse(w_change)
  );
  debounce #(.DEPTH(DB_DEPTH)) u_db_bin (
    .clk(clk), .rst_n(w_rst_n), .i_raw(bin), .o_pulse(w_bin_pulse)
  );

  // The engine takes B straight from the switches and borrow-in from the pre-toggle flag
  serial_subtractor_4bit u_engine (
    .clk(clk), .rst(rst), .start(w_start), .a(r_num_a), .b(Input),
    .bin(r_bin_status), .diff(w_diff), .bout(w_eng_bout), .done(w_done)
  );

  segment_decoder u_seg (
    .i_num(r_show_number), .o_seg_tens(seg1), .o_seg_units(seg2)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_A;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_A:     w_next_state = w_change ? S_B : S_A;
      S_B:     w_next_state = w_change ? S_CALC : S_B;
      S_CALC:  w_next_state = w_done ? S_SHOW : S_CALC;
      S_SHOW:  w_next_state = w_change ? S_A : S_SHOW;
      default: w_next_state = S_A;
    endcase
  end

  // Per-state control strobes
  always_comb begin
    w_start       = 1'b0;
    w_bin_allowed = 1'b1;
    case (r_state)
      S_B:     begin w_start = w_change; w_bin_allowed = 1'b1; end
      S_CALC:  begin w_start = 1'b0;     w_bin_allowed = 1'b0; end
      default: begin w_start = 1'b0;     w_bin_allowed = 1'b1; end
    endcase
  end

  // Operand, display and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_num_a       <= '0;
      r_show_number <= '0;
      r_bout        <= 1'b0;
      r_busy        <= 1'b0;
      r_bin_status  <= 1'b0;
    end else begin
      if (w_bin_pulse && w_bin_allowed) begin
        r_bin_status <= ~r_bin_status;
      end
      case (r_state)
        S_A: if (w_change) begin
          r_num_a       <= Input;
          r_show_number <= Input;
        end
        S_B: if (w_change) begin
          r_show_number <= Input;
          r_busy        <= 1'b1;
        end
        S_CALC: if (w_done) begin
          r_show_number <= w_diff;
          r_bout        <= w_eng_bout;
          r_busy        <= 1'b0;
        end
        S_SHOW: if (w_change) begin
          r_num_a       <= '0;
          r_show_number <= '0;
          r_bout        <= 1'b0;
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign bin_status = r_bin_status;
  assign bout       = r_bout;
  assign busy       = r_busy;
endmodule

// File: tb/tb_serial_subtractor_calc.sv
// Self-checking bench for serial_subtractor_calc.
// It applies a vector table, hand sequences, random operations and an exhaustive sweep against an arithmetic model.
module tb_serial_subtractor_calc;
  logic       clk = 1'b0;
  logic       rst, btn, bin;
  logic [3:0] sw;
  logic [7:0] seg1, seg2;
  logic       bin_status, bout, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_cnt = 0;
  bit m_bin = 1'b0;

  typedef struct {
    int a; int b; bit bi; int exp_d; bit exp_bo;
  } vec_t;

  always #5 clk = ~clk;

  serial_subtractor_calc dut (
    .clk(clk), .rst(rst), .Input(sw), .btn(btn), .bin(bin),
    .seg1(seg1), .seg2(seg2), .bin_status(bin_status), .bout(bout), .busy(busy)
  );

  always @(negedge clk) if (busy === 1'b1) busy_cnt++;

  function automatic logic [7:0] glyph(input int d);
    case (d)
      0: return 8'h3F; 1: return 8'h06; 2: return 8'h5B; 3: return 8'h4F;
      4: return 8'h66; 5: return 8'h6D; 6: return 8'h7D; 7: return 8'h07;
      8: return 8'h7F; 9: return 8'h6F; default: return 8'h00;
    endcase
  endfunction

  function automatic int ref_diff(input int a, input int b, input int bi);
    return (a - b - bi + 32) % 16;
  endfunction

  function automatic bit ref_bout(input int a, input int b, input int bi);
    return (a < b + bi);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_disp(input string name, input int n);
    check(name, int'({seg1, seg2}), int'({glyph(n / 10), glyph(n % 10)}));
  endtask

  // Hold the raw buttons long enough to be accepted, then release and let the release settle
  task automatic press(input bit do_btn, input bit do_bin, input int bin_delay);
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (do_btn && i == 0) btn = 1'b1;
      if (do_bin && i == bin_delay) bin = 1'b1;
      @(negedge clk);
    end
    btn = 1'b0;
    bin = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic set_bin(input bit want);
    if (m_bin != want) begin
      press(1'b0, 1'b1, 0);
      m_bin = ~m_bin;
      check("bin_toggle", bin_status, m_bin);
    end
  endtask

  task automatic run_op(input int a, input int b, input bit bi, input int exp_d, input bit exp_bo);
    set_bin(bi);
    sw = 4'(a);
    press(1'b1, 1'b0, 0);
    check_disp($sformatf("disp_a[%0d]", a), a);
    check("busy_idle", busy, 0);
    sw = 4'(b);
    press(1'b1, 1'b0, 0);
    check("busy_cycles", busy_cnt, 5);
    check_disp($sformatf("result[%0d-%0d-%0d]", a, b, bi), exp_d);
    check($sformatf("bout[%0d-%0d-%0d]", a, b, bi), bout, exp_bo);
    check("bin_kept", bin_status, m_bin);
    press(1'b1, 1'b0, 0);
    check_disp("clear_disp", 0);
    check("clear_bout", bout, 0);
  endtask

  initial begin
    vec_t vecs[7];
    int k;
    int ra, rb, rbi;
    vecs[0] = '{9, 4, 1'b0, 5, 1'b0};
    vecs[1] = '{3, 5, 1'b0, 14, 1'b1};
    vecs[2] = '{0, 0, 1'b1, 15, 1'b1};
    vecs[3] = '{15, 15, 1'b1, 15, 1'b1};
    vecs[4] = '{15, 0, 1'b0, 15, 1'b0};
    vecs[5] = '{0, 15, 1'b0, 1, 1'b1};
    vecs[6] = '{8, 7, 1'b1, 0, 1'b0};

    rst = 1'b1; btn = 1'b0; bin = 1'b0; sw = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_disp("reset_disp", 0);
    check("reset_bout", bout, 0);
    check("reset_busy", busy, 0);
    check("reset_bin", bin_status, 0);

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].bi, vecs[i].exp_d, vecs[i].exp_bo);

    // bin press landing inside the calculation is ignored; the captured borrow-in stays 1
    set_bin(1'b1);
    sw = 4'd6;
    press(1'b1, 1'b0, 0);
    sw = 4'd9;
    press(1'b1, 1'b1, 2);
    check("calc_busy_cycles", busy_cnt, 5);
    check_disp("calc_ignore_result", 12);
    check("calc_ignore_bout", bout, 1);
    check("calc_ignore_bin", bin_status, 1);
    press(1'b1, 1'b0, 0);
    check_disp("show_to_a_disp", 0);
    check("show_to_a_bout", bout, 0);
    check("show_to_a_bin", bin_status, 1);

    // btn and bin together in S_B: the capture sees the old flag, which then toggles
    sw = 4'd10;
    press(1'b1, 1'b0, 0);
    sw = 4'd3;
    press(1'b1, 1'b1, 0);
    m_bin = 1'b0;
    check_disp("sb_both_result", 6);
    check("sb_both_bout", bout, 0);
    check("sb_both_bin", bin_status, 0);
    press(1'b1, 1'b0, 0);
    // Same in S_A: both take effect
    sw = 4'd4;
    press(1'b1, 1'b1, 0);
    m_bin = 1'b1;
    check_disp("sa_both_disp", 4);
    check("sa_both_bin", bin_status, 1);
    press(1'b1, 1'b0, 0);
    check_disp("sa_both_result", 15);
    check("sa_both_bout", bout, 1);
    press(1'b1, 1'b0, 0);

    // Reset in the second cycle of the calculation
    sw = 4'd7;
    press(1'b1, 1'b0, 0);
    sw = 4'd2;
    btn = 1'b1;
    k = 0;
    while (busy !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("rst_busy_seen", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    btn = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_bout", bout, 0);
    check("rst_mid_bin", bin_status, 0);
    check_disp("rst_mid_disp", 0);
    m_bin = 1'b0;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_after_busy", busy, 0);
    check_disp("rst_after_disp", 0);
    run_op(7, 2, 1'b0, 5, 1'b0);

    for (int i = 0; i < 30; i++) begin
      ra  = int'($urandom_range(15, 0));
      rb  = int'($urandom_range(15, 0));
      rbi = int'($urandom_range(1, 0));
      run_op(ra, rb, rbi[0], ref_diff(ra, rb, rbi), ref_bout(ra, rb, rbi));
    end

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int bi = 0; bi < 2; bi++)
          run_op(a, b, bi[0], ref_diff(a, b, bi), ref_bout(a, b, bi));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
